// File: rtl/bullet_pool_if.sv
// Bullet pool bus: ship/fire/collision inputs in, slot state and event pulses out.
interface bullet_pool_if #(
  parameter int N_BULLETS = 30,
  parameter int COORD_W   = 10
);
  logic                             fire;
  logic [COORD_W-1:0]               ship_x;
  logic [COORD_W-1:0]               ship_y;
  logic [N_BULLETS-1:0]             collided;
  logic [2*COORD_W*N_BULLETS-1:0]   bullet_pos;
  logic [N_BULLETS-1:0]             active;
  logic                             spawned;
  logic                             dropped;
  logic [5:0]                       n_active;

  // Game/collision side drives requests and observes the pool.
  modport master (
    output fire, ship_x, ship_y, collided,
    input  bullet_pos, active, spawned, dropped, n_active
  );

  // The pool itself.
  modport slave (
    input  fire, ship_x, ship_y, collided,
    output bullet_pos, active, spawned, dropped, n_active
  );
endinterface

// File: rtl/bullet_pool.sv
// Player projectile pool: lowest-free-slot spawn with cooldown, divided-tick
// upward motion, retirement on collision or top edge, and a pixel colour probe.
module bullet_pool #(
  parameter int          N_BULLETS  = 30,
  parameter int          COORD_W    = 10,
  parameter int          COOLDOWN   = 5000000,
  parameter int          CD_W       = 32,
  parameter int          MOVE_DIV   = 250000,
  parameter int          SPEED      = 2,
  parameter int          SPAWN_DX   = 13,
  parameter int          SPAWN_DY   = 10,
  parameter int          BW         = 4,
  parameter int          BH         = 8,
  parameter logic [23:0] BULLET_RGB = 24'hFFFF00
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [23:0]        rgb,
  bullet_pool_if.slave       bus
);

  localparam int IW = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;
  localparam int WW = COORD_W + 1;

  logic [N_BULLETS-1:0] active_q, active_n;
  logic [COORD_W-1:0]   xs_q [N_BULLETS];
  logic [COORD_W-1:0]   ys_q [N_BULLETS];
  logic [COORD_W-1:0]   xs_n [N_BULLETS];
  logic [COORD_W-1:0]   ys_n [N_BULLETS];
  logic [CD_W-1:0]      cnt_q, cnt_n;
  logic [31:0]          tick_q, tick_n;
  logic                 spawned_q, dropped_q;
  logic [5:0]           n_active_q, n_active_n;

  logic [IW-1:0]        free_idx;
  logic                 any_free, ready, tick, spawn, drop, y_ok;

  // Lowest-index free slot, from the state before this edge.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    free_idx = '0;
    any_free = 1'b0;
    for (int i = 0; i < N_BULLETS; i++) begin
      if (!any_free && !active_q[i]) begin
        free_idx = IW'(i);
        any_free = 1'b1;
      end
    end
  end

  // Next-state: collision beats motion; spawn lands only in a slot free before this edge.
  always_comb begin
    ready = (cnt_q == '0);
    tick  = (tick_q == 32'(MOVE_DIV - 1));
    y_ok  = ({1'b0, bus.ship_y} >= WW'(SPAWN_DY));
    spawn = bus.fire && ready && y_ok && any_free;
    drop  = bus.fire && ready && !any_free;

    active_n = active_q;
    for (int i = 0; i < N_BULLETS; i++) begin
      xs_n[i] = xs_q[i];
      ys_n[i] = ys_q[i];
      if (active_q[i]) begin
        if (bus.collided[i]) begin
          active_n[i] = 1'b0;
        end else if (tick) begin
          if ({1'b0, ys_q[i]} >= WW'(SPEED)) ys_n[i] = ys_q[i] - COORD_W'(SPEED);
          else                               active_n[i] = 1'b0;
        end
      end
      if (spawn && (free_idx == IW'(i))) begin
        active_n[i] = 1'b1;
        xs_n[i]     = bus.ship_x + COORD_W'(SPAWN_DX);
        ys_n[i]     = bus.ship_y - COORD_W'(SPAWN_DY);
      end
    end

    if (spawn)             cnt_n = CD_W'(COOLDOWN - 1);
    else if (cnt_q != '0)  cnt_n = cnt_q - 1'b1;
    else                   cnt_n = cnt_q;

    tick_n = tick ? '0 : tick_q + 1'b1;

    n_active_n = '0;
    for (int i = 0; i < N_BULLETS; i++) n_active_n = n_active_n + 6'(active_n[i]);
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      active_q   <= '0;
      cnt_q      <= '0;
      tick_q     <= '0;
      spawned_q  <= 1'b0;
      dropped_q  <= 1'b0;
      n_active_q <= '0;
      // NOTE: the coordinate arrays are reset too so the packed position bus is defined after reset.
      for (int i = 0; i < N_BULLETS; i++) begin
        xs_q[i] <= '0;
        ys_q[i] <= '0;
      end
    end else begin
      active_q   <= active_n;
      cnt_q      <= cnt_n;
      tick_q     <= tick_n;
      spawned_q  <= spawn;
      dropped_q  <= drop;
      n_active_q <= n_active_n;
      for (int i = 0; i < N_BULLETS; i++) begin
        xs_q[i] <= xs_n[i];
        ys_q[i] <= ys_n[i];
      end
    end
  end

  // Output packing towards the collision logic.
  always_comb begin
    bus.bullet_pos = '0;
    for (int i = 0; i < N_BULLETS; i++)
      bus.bullet_pos[2*COORD_W*i +: 2*COORD_W] = {ys_q[i], xs_q[i]};
    bus.active   = active_q;
    bus.spawned  = spawned_q;
    bus.dropped  = dropped_q;
    bus.n_active = n_active_q;
  end

  // Pixel hit test with widened comparisons so boxes near the edge do not wrap.
  always_comb begin
    rgb = 24'h000000;
    for (int i = 0; i < N_BULLETS; i++) begin
      if (active_q[i] &&
          ({1'b0, x} >= {1'b0, xs_q[i]}) && ({1'b0, x} < ({1'b0, xs_q[i]} + WW'(BW))) &&
          ({1'b0, y} >= {1'b0, ys_q[i]}) && ({1'b0, y} < ({1'b0, ys_q[i]} + WW'(BH))))
        rgb = BULLET_RGB;
    end
  end

endmodule

// File: tb/tb_bullet_pool.sv
// Randomised scoreboard bench for bullet_pool against a slot-level reference model.
module tb_bullet_pool;
  localparam int N   = 4;
  localparam int CW  = 10;
  localparam int CD  = 4;
  localparam int MD  = 8;
  localparam int SP  = 2;
  localparam int DX  = 13;
  localparam int DY  = 10;
  localparam int BW  = 4;
  localparam int BH  = 8;
  localparam logic [23:0] COLOUR = 24'hFFFF00;

  typedef struct {
    logic [N-1:0]      active;
    logic [5:0]        n_active;
    logic              spawned;
    logic              dropped;
    logic [2*CW*N-1:0] pos;
    logic [23:0]       rgb;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [CW-1:0] x, y;
  logic [23:0]   rgb;

  bullet_pool_if #(.N_BULLETS(N), .COORD_W(CW)) bus ();

  bullet_pool #(
    .N_BULLETS(N), .COORD_W(CW), .COOLDOWN(CD), .CD_W(32), .MOVE_DIV(MD),
    .SPEED(SP), .SPAWN_DX(DX), .SPAWN_DY(DY), .BW(BW), .BH(BH), .BULLET_RGB(COLOUR)
  ) dut (
    .clock(clock), .reset(reset), .x(x), .y(y), .rgb(rgb), .bus(bus.slave)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];

  // Reference model state: one record per slot plus the two counters.
  bit m_act [N];
  int m_x   [N];
  int m_y   [N];
  int m_cnt;
  int m_tick;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, advance the model, queue the expectation.
  task automatic cycle(input bit rst, input bit f, input int sx, input int sy,
                       input logic [N-1:0] col, input int px, input int py);
    exp_t e;
    int k;
    bit sp, dr, tk;
    @(negedge clock);
    reset = rst; bus.fire = f; bus.ship_x = CW'(sx); bus.ship_y = CW'(sy);
    bus.collided = col; x = CW'(px); y = CW'(py);
    sp = 0; dr = 0;
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
      m_cnt = 0; m_tick = 0;
    end else begin
      k = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_act[i]) k = i;
      sp = f && m_cnt == 0 && sy >= DY && k >= 0;
      dr = f && m_cnt == 0 && k < 0;
      tk = (m_tick == MD - 1);
      for (int i = 0; i < N; i++) begin
        if (!m_act[i]) continue;
        if (col[i]) m_act[i] = 0;
        else if (tk) begin
          if (m_y[i] >= SP) m_y[i] -= SP;
          else              m_act[i] = 0;
        end
      end
      if (sp) begin
        m_act[k] = 1; m_x[k] = (sx + DX) % 1024; m_y[k] = sy - DY;
      end
      m_cnt  = sp ? CD - 1 : (m_cnt > 0 ? m_cnt - 1 : 0);
      m_tick = tk ? 0 : m_tick + 1;
    end
    e.spawned = sp; e.dropped = dr; e.rgb = 24'h0; e.n_active = 0; e.pos = '0;
    for (int i = 0; i < N; i++) begin
      e.active[i] = m_act[i];
      e.n_active += 6'(m_act[i]);
      e.pos[2*CW*i +: 2*CW] = {CW'(m_y[i]), CW'(m_x[i])};
      if (m_act[i] && px >= m_x[i] && px < m_x[i] + BW && py >= m_y[i] && py < m_y[i] + BH)
        e.rgb = COLOUR;
    end
    q.push_back(e);
  endtask

  // Monitor: compares after every edge for which an expectation was queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("active",   80'(bus.active),     80'(e.active));
        check("n_active", 80'(bus.n_active),   80'(e.n_active));
        check("spawned",  80'(bus.spawned),    80'(e.spawned));
        check("dropped",  80'(bus.dropped),    80'(e.dropped));
        check("pos",      80'(bus.bullet_pos), 80'(e.pos));
        check("rgb",      80'(rgb),            80'(e.rgb));
      end
    end
  end

  // Pixel near a random slot's box edges so both hit and miss sides get exercised.
  function automatic int near_x(int j);
    return (m_x[j] + int'($urandom_range(0, BW + 1)) - 1 + 1024) % 1024;
  endfunction
  function automatic int near_y(int j);
    return (m_y[j] + int'($urandom_range(0, BH + 1)) - 1 + 1024) % 1024;
  endfunction

  initial begin
    int j, sy, sx;
    logic [N-1:0] col;
    reset = 1; bus.fire = 0; bus.ship_x = '0; bus.ship_y = '0; bus.collided = '0; x = '0; y = '0;
    for (int i = 0; i < N; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
    m_cnt = 0; m_tick = 0;

    cycle(1, 0, 0, 0, '0, 0, 0);
    cycle(1, 1, 100, 200, '0, 0, 0);
    // Fire held from reset release: fills the pool, then reports drops.
    for (int c = 0; c < 30; c++) cycle(0, 1, 100, 200, '0, 113 + (c % 5), 190 + (c % 9));
    // Free slot 1 while the pool is full and fire is held.
    cycle(0, 1, 100, 200, 4'b0010, 117, 198);
    for (int c = 0; c < 6; c++) cycle(0, 1, 100, 200, '0, 116, 197);
    // Top edge: ship just below and at the spawn offset.
    cycle(0, 0, 100, 200, 4'b1111, 0, 0);
    for (int c = 0; c < 6; c++) cycle(0, 1, 50, 5, '0, 63, 0);
    for (int c = 0; c < 20; c++) cycle(0, 1, 50, 10, '0, 63, 0);

    // Randomised traffic, including right-edge x wrap and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      j   = int'($urandom_range(0, N - 1));
      sy  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 40));
      sx  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1005, 1023)) : int'($urandom_range(0, 1023));
      col = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0), sx, sy, col,
            near_x(j), near_y(j));
    end

    // Reset mid-flight with a pixel on a live bullet.
    for (int c = 0; c < 8; c++) cycle(0, 1, 200, 300, '0, 213, 290);
    cycle(1, 1, 200, 300, '0, 213, 290);
    cycle(0, 0, 200, 300, '0, 213, 290);

    repeat (3) @(posedge clock);
    #2;
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bullet_pool.md
Name: bullet_pool

Overview:
Parametrised player-projectile pool that owns N_BULLETS slots, each with its own position and active state.
- Spawns a bullet at the ship muzzle into the lowest free slot, rate-limited by a cooldown counter.
- Moves all active bullets upward on a divided motion tick, and retires them on collision or when they leave the top edge.
- Exports packed positions and an active mask to the collision logic, and a per-pixel RGB to the VGA compositor.

Parameters:
N_BULLETS, 30, number of bullet slots (1..32)
COORD_W, 10, width of each x/y coordinate
COOLDOWN, 5000000, minimum clocks between successive spawns (>=1)
CD_W, 32, cooldown counter width
MOVE_DIV, 250000, clocks per motion tick (>=1)
SPEED, 2, pixels moved upward per motion tick
SPAWN_DX, 13, x offset from ship_x to muzzle
SPAWN_DY, 10, y offset above ship_y to muzzle
BW, 4, bullet width in pixels
BH, 8, bullet height in pixels
BULLET_RGB, 24'hFFFF00, bullet draw colour

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
ship_x  in  COORD_W  ship left x
ship_y  in  COORD_W  ship top y
x  in  COORD_W  current pixel x
y  in  COORD_W  current pixel y
fire  in  1  fire request level
collided  in  N_BULLETS  per-slot collision pulse from hit detection
bullet_pos  out  2*COORD_W*N_BULLETS  slot i at [2*COORD_W*i +: 2*COORD_W] = {y_i, x_i}
active  out  N_BULLETS  slot occupied mask
spawned  out  1  1-cycle pulse: a bullet spawned this cycle
dropped  out  1  1-cycle pulse: fire was ready but no free slot
n_active  out  6  population count of active
rgb  out  24  pixel colour

Behaviour:
- Interface: one clock `clock`; `reset` is synchronous and active-high.
- Reset values: active=0, all x_i/y_i=0, cooldown cnt=0 (ready), tick counter=0, spawned=0, dropped=0. Reset mid-flight clears all slots on the next edge.
- Cooldown: when cnt!=0 it decrements by 1 every clock, regardless of fire.
- Spawn condition: fire && cnt==0 && ship_y>=SPAWN_DY && some slot has active=0.
  - Slot k = lowest index with active=0, sampled before this edge's updates.
  - Next edge: active[k]=1, x_k=ship_x+SPAWN_DX (mod 2^COORD_W), y_k=ship_y-SPAWN_DY, cnt=COOLDOWN-1, spawned=1.
  - Fire held continuously: spawns are exactly COOLDOWN clocks apart.
- No free slot: if fire && cnt==0 && no slot free, then no spawn, dropped=1, cnt stays 0 (fires on the first cycle a slot frees).
- Top edge at spawn: if fire && cnt==0 && ship_y<SPAWN_DY, no spawn and no dropped; cnt stays 0.
- Motion tick: the tick counter counts 0..MOVE_DIV-1 and ticks when it equals MOVE_DIV-1. On a tick, each active slot with y_i>=SPEED gets y_i-=SPEED. An active slot with y_i<SPEED gets active=0 (off-screen); its coordinates hold.
- Collision: collided[i]=1 clears active[i] on the next edge and takes priority over motion. collided on an inactive slot is ignored.
- Simultaneous events:
  - A slot freed this cycle by collision or off-screen is not eligible for spawn until the following cycle.
  - The newly spawned slot does not move on a coincident tick.
- Slot ordering: no round-robin; freed slots are reused lowest-index first.
- n_active = popcount(active), registered outputs consistent with active.
- rgb (combinational from registers): hit_i = active[i] && x>=x_i && x<x_i+BW && y>=y_i && y<y_i+BH, with comparisons widened by 1 bit so there is no wrap. rgb = BULLET_RGB if any hit_i, else 24'h000000.

Test Plan:
- Reset then fire held, COOLDOWN=4, MOVE_DIV large, ship=(100,200) -> slot0 at {y=190,x=113} one edge after release; slots 1,2,3 follow at 4-clock spacing; spawned pulses exactly 4 clocks apart.
- N_BULLETS=4, fire held until all four slots are full -> dropped=1 on each ready cycle, n_active=4. Pulse collided=4'b0010 -> active=4'b1101 next edge; the next spawn lands in slot1.
- MOVE_DIV=2, SPEED=2, bullet spawned at y=5 -> y goes 3 then 1, then active clears on the following tick; n_active decrements.
- Collision and tick in the same cycle on slot0 -> slot0 inactive, y unchanged. Fire ready in the same cycle with all other slots full -> dropped=1, no spawn into slot0 that cycle.
- ship_y=5, SPAWN_DY=10, fire -> no spawn, no dropped, cnt stays 0. ship_y=10 -> spawn at y=0, retired on the first tick.
- Pixel probe, bullet at (113,190), BW=4, BH=8: (113,190) and (116,197) -> 24'hFFFF00; (117,190) and (113,198) -> 0. Assert reset mid-flight -> rgb=0, active=0, n_active=0 on the next edge.
